rsa_job_arbiter: RTL and testbench
==================================

Name: rsa_job_arbiter

Overview:
- Two-requester scheduler for one shared RSA `control` core instance (the p/q key setup inverter plus the modular-exponentiation datapath).
- Arbitrates round-robin between requester 0 and requester 1, latches the winner's operands, and sequences the core:
  - inverter reset pulse, then wait for `inverter_finish`;
  - mod-exp reset pulse, then wait for `mod_exp_finish`.
- Captures the core's `msg_out` and returns it to the winning requester.
- Skips key setup when p/q match the last completed key.

Parameters:
- WIDTH, 128, prime width; messages are 2*WIDTH bits.
- TIMEOUT_CYCLES, 65535, watchdog limit per wait state (used only with RSA_WATCHDOG_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0, req1  input  1 each  level request; held until matching done.
- enc_dec0, enc_dec1  input  1 each  encrypt_decrypt select passed to the core.
- p0, q0, p1, q1  input  WIDTH each  requester primes.
- msg0, msg1  input  2*WIDTH each  requester message.
- grant0, grant1  output  1 each  high from grant until done, inclusive.
- done0, done1  output  1 each  one-cycle completion pulse.
- err  output  1  valid with done; 1 = watchdog abort.
- result  output  2*WIDTH  captured core msg_out; held until the next done.
- busy  output  1  high whenever state is not IDLE.
- core_p, core_q  output  WIDTH each  to core p/q.
- core_encrypt_decrypt  output  1  to core.
- core_msg_in  output  2*WIDTH  to core.
- core_reset_inverter, core_reset_mod_exp  output  1 each  one-cycle start pulses.
- core_inverter_finish, core_mod_exp_finish  input  1 each  from core.
- core_msg_out  input  2*WIDTH  from core.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - All outputs 0, including result; core_* operand registers 0.
  - last_served = 1, so req0 wins the first tie.
  - key_valid = 0.
- States: IDLE, INV_RST, INV_GUARD, INV_WAIT, EXP_RST, EXP_GUARD, EXP_WAIT, DONE.
- IDLE:
  - Requests are sampled only here.
  - If exactly one req is high, grant it. If both are high, grant the one not equal to last_served.
  - On grant, in the same edge: latch p/q/msg/enc_dec into the core_* registers, set grant_i, update last_served.
  - If key_valid and p/q equal the stored key, go to EXP_RST; otherwise go to INV_RST.
- INV_RST:
  - core_reset_inverter = 1 for exactly one cycle, then INV_GUARD.
- INV_GUARD:
  - Finish inputs are ignored for this one cycle, which masks stale finish levels; then INV_WAIT.
- INV_WAIT:
  - Stay until core_inverter_finish = 1.
  - Then store key = (core_p, core_q), set key_valid = 1, go to EXP_RST.
- EXP_RST:
  - core_reset_mod_exp = 1 for exactly one cycle, then EXP_GUARD.
- EXP_GUARD:
  - Finish inputs are ignored for this one cycle; then EXP_WAIT.
- EXP_WAIT:
  - Stay until core_mod_exp_finish = 1.
  - Then result <= core_msg_out, err <= 0, go to DONE.
- DONE:
  - done_i = 1 for one cycle, grant_i cleared at the end of the cycle, return to IDLE.
  - A req still high in the following IDLE cycle is treated as a new job.
- Minimum latency, grant edge to done pulse:
  - cold key: 6 cycles plus inverter wait plus mod-exp wait;
  - cached key: 3 cycles plus mod-exp wait.
- Core operand registers are stable from grant through DONE. Requester inputs may change freely after grant.
- A req dropped mid-job is ignored: the job completes and done still pulses.
- Reset mid-job aborts immediately:
  - no done pulse;
  - key_valid cleared;
  - core reset pulses deasserted asynchronously.
- The core's reset_inverter and reset_mod_exp are never high simultaneously.

Optional Feature:
- Macro: RSA_WATCHDOG_EN.
- With the macro defined:
  - A 32-bit counter clears on entry to INV_WAIT and EXP_WAIT and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES: go to DONE with err = 1, result = 0, key_valid = 0.
- Without the macro: no counter exists and err is constant 0.

Test Plan:
- req0 with p=113680897410347, q=7999808077935876437321, enc_dec=0, msg=256'h3e18<<88, core model finishing after 20/40 cycles:
  - one core_reset_inverter pulse, then one core_reset_mod_exp pulse;
  - done0 pulses once, result = model output.
- Repeat the same p/q from req1 with enc_dec=1:
  - no core_reset_inverter pulse;
  - done1 pulses 3 + 40 cycles after grant.
- req0 and req1 both high at reset release:
  - grant order 0, 1, 0, 1 over four jobs;
  - busy is never low between back-to-back jobs longer than one IDLE cycle.
- Stale high core_inverter_finish held during INV_RST/INV_GUARD:
  - arbiter does not advance until finish is seen in INV_WAIT.
- Assert reset during EXP_WAIT:
  - all outputs return to 0 asynchronously;
  - next job with identical p/q performs the inverter step.
- With RSA_WATCHDOG_EN and TIMEOUT_CYCLES=100, core never finishes:
  - done0 with err=1 and result=0 at entry to INV_WAIT + 100 cycles.

Source files
------------

// File: rtl/rsa_job_arbiter.sv
// rsa_job_arbiter: round-robin scheduler sharing one RSA control core between two requesters.
// Define RSA_WATCHDOG_EN to add a per-wait-state timeout that aborts a job with err.
module rsa_job_arbiter #(
    parameter int WIDTH          = 128,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 enc_dec0,
    input  logic                 enc_dec1,
    input  logic [WIDTH-1:0]     p0,
    input  logic [WIDTH-1:0]     q0,
    input  logic [WIDTH-1:0]     p1,
    input  logic [WIDTH-1:0]     q1,
    input  logic [2*WIDTH-1:0]   msg0,
    input  logic [2*WIDTH-1:0]   msg1,
    output logic                 grant0,
    output logic                 grant1,
    output logic                 done0,
    output logic                 done1,
    output logic                 err,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic [WIDTH-1:0]     core_p,
    output logic [WIDTH-1:0]     core_q,
    output logic                 core_encrypt_decrypt,
    output logic [2*WIDTH-1:0]   core_msg_in,
    output logic                 core_reset_inverter,
    output logic                 core_reset_mod_exp,
    input  logic                 core_inverter_finish,
    input  logic                 core_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   core_msg_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INV_RST,
        S_INV_GUARD,
        S_INV_WAIT,
        S_EXP_RST,
        S_EXP_GUARD,
        S_EXP_WAIT,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 last_q, last_d;
    logic                 key_valid_q, key_valid_d;
    logic [WIDTH-1:0]     key_p_q, key_p_d;
    logic [WIDTH-1:0]     key_q_q, key_q_d;
    logic [WIDTH-1:0]     op_p_q, op_p_d;
    logic [WIDTH-1:0]     op_q_q, op_q_d;
    logic                 op_enc_q, op_enc_d;
    logic [2*WIDTH-1:0]   op_msg_q, op_msg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 any_req;
    logic                 pick1;
    logic                 key_hit;
    logic [WIDTH-1:0]     win_p;
    logic [WIDTH-1:0]     win_q;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_must_be_positive
    end

`ifdef RSA_WATCHDOG_EN
    logic                 err_q, err_d;
    logic [31:0]          wd_q, wd_d;
    logic                 wd_expired;

    assign wd_expired = (wd_q == 32'(TIMEOUT_CYCLES - 1));
`endif

    // On a tie, serve the requester that was not served last.
    assign any_req = req0 | req1;
    assign pick1   = req1 & (~req0 | ~last_q);
    assign win_p   = pick1 ? p1 : p0;
    assign win_q   = pick1 ? q1 : q0;
    assign key_hit = key_valid_q && (key_p_q == win_p) && (key_q_q == win_q);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        key_valid_d = key_valid_q;
        key_p_d     = key_p_q;
        key_q_d     = key_q_q;
        op_p_d      = op_p_q;
        op_q_d      = op_q_q;
        op_enc_d    = op_enc_q;
        op_msg_d    = op_msg_q;
        result_d    = result_q;
`ifdef RSA_WATCHDOG_EN
        err_d       = err_q;
        wd_d        = wd_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d  = pick1 ? 2'b10 : 2'b01;
                    last_d   = pick1;
                    op_p_d   = win_p;
                    op_q_d   = win_q;
                    op_enc_d = pick1 ? enc_dec1 : enc_dec0;
                    op_msg_d = pick1 ? msg1 : msg0;
                    state_d  = key_hit ? S_EXP_RST : S_INV_RST;
                end
            end
            S_INV_RST: state_d = S_INV_GUARD;
            S_INV_GUARD: begin
                state_d = S_INV_WAIT;
`ifdef RSA_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            S_INV_WAIT: begin
                if (core_inverter_finish) begin
                    key_p_d     = op_p_q;
                    key_q_d     = op_q_q;
                    key_valid_d = 1'b1;
                    state_d     = S_EXP_RST;
                end
`ifdef RSA_WATCHDOG_EN
                else if (wd_expired) begin
                    state_d     = S_DONE;
                    err_d       = 1'b1;
                    result_d    = '0;
                    key_valid_d = 1'b0;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
`endif
            end
            S_EXP_RST: state_d = S_EXP_GUARD;
            S_EXP_GUARD: begin
                state_d = S_EXP_WAIT;
`ifdef RSA_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            S_EXP_WAIT: begin
                if (core_mod_exp_finish) begin
                    result_d = core_msg_out;
                    state_d  = S_DONE;
`ifdef RSA_WATCHDOG_EN
                    err_d    = 1'b0;
`endif
                end
`ifdef RSA_WATCHDOG_EN
                else if (wd_expired) begin
                    state_d     = S_DONE;
                    err_d       = 1'b1;
                    result_d    = '0;
                    key_valid_d = 1'b0;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
`endif
            end
            S_DONE: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            key_valid_q <= 1'b0;
            key_p_q     <= '0;
            key_q_q     <= '0;
            op_p_q      <= '0;
            op_q_q      <= '0;
            op_enc_q    <= 1'b0;
            op_msg_q    <= '0;
            result_q    <= '0;
`ifdef RSA_WATCHDOG_EN
            err_q       <= 1'b0;
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            key_valid_q <= key_valid_d;
            key_p_q     <= key_p_d;
            key_q_q     <= key_q_d;
            op_p_q      <= op_p_d;
            op_q_q      <= op_q_d;
            op_enc_q    <= op_enc_d;
            op_msg_q    <= op_msg_d;
            result_q    <= result_d;
`ifdef RSA_WATCHDOG_EN
            err_q       <= err_d;
            wd_q        <= wd_d;
`endif
        end
    end

    // Start pulses decode straight from state so reset drops them asynchronously.
    assign core_reset_inverter  = (state_q == S_INV_RST);
    assign core_reset_mod_exp   = (state_q == S_EXP_RST);
    assign busy                 = (state_q != S_IDLE);
    assign grant0               = grant_q[0];
    assign grant1               = grant_q[1];
    assign done0                = (state_q == S_DONE) & grant_q[0];
    assign done1                = (state_q == S_DONE) & grant_q[1];
    assign result               = result_q;
    assign core_p               = op_p_q;
    assign core_q               = op_q_q;
    assign core_encrypt_decrypt = op_enc_q;
    assign core_msg_in          = op_msg_q;
`ifdef RSA_WATCHDOG_EN
    assign err                  = err_q;
`else
    assign err                  = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Scoreboard bench for rsa_job_arbiter with a behavioural RSA core model.
// Define RSA_WATCHDOG_EN to also exercise the timeout path (TIMEOUT_CYCLES = 100).
module tb_rsa_job_arbiter;

    localparam int W      = 128;
    localparam int MW     = 2 * W;
    localparam int BUDGET = 3000;
`ifdef RSA_WATCHDOG_EN
    localparam int TO = 100;
`else
    localparam int TO = 65535;
`endif

    typedef struct {
        logic [MW-1:0] res;
        logic          err;
        int            inv;
        int            mod;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          enc_dec0 = 1'b0, enc_dec1 = 1'b0;
    logic [W-1:0]  p0 = '0, q0 = '0, p1 = '0, q1 = '0;
    logic [MW-1:0] msg0 = '0, msg1 = '0;
    logic          grant0, grant1, done0, done1, err, busy;
    logic [MW-1:0] result, core_msg_in, core_msg_out;
    logic [W-1:0]  core_p, core_q;
    logic          core_encrypt_decrypt;
    logic          core_reset_inverter, core_reset_mod_exp;
    logic          core_inverter_finish, core_mod_exp_finish;

    rsa_job_arbiter #(
        .WIDTH(W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req0(req0),
        .req1(req1),
        .enc_dec0(enc_dec0),
        .enc_dec1(enc_dec1),
        .p0(p0),
        .q0(q0),
        .p1(p1),
        .q1(q1),
        .msg0(msg0),
        .msg1(msg1),
        .grant0(grant0),
        .grant1(grant1),
        .done0(done0),
        .done1(done1),
        .err(err),
        .result(result),
        .busy(busy),
        .core_p(core_p),
        .core_q(core_q),
        .core_encrypt_decrypt(core_encrypt_decrypt),
        .core_msg_in(core_msg_in),
        .core_reset_inverter(core_reset_inverter),
        .core_reset_mod_exp(core_reset_mod_exp),
        .core_inverter_finish(core_inverter_finish),
        .core_mod_exp_finish(core_mod_exp_finish),
        .core_msg_out(core_msg_out)
    );

    always #5 clk = ~clk;

    // Core model: finish rises so the arbiter waits exactly li/lm extra cycles.
    int            li = 0, lm = 0;
    int            inv_cnt = 0, exp_cnt = 0;
    logic          inv_fin = 1'b0, exp_fin = 1'b0, stale_inv = 1'b0;
    logic [MW-1:0] model_out = '0;

    always @(posedge clk) begin
        if (core_reset_inverter) begin
            inv_cnt <= li + 1;
            inv_fin <= 1'b0;
        end else if (inv_cnt != 0) begin
            inv_cnt <= inv_cnt - 1;
            if (inv_cnt == 1) inv_fin <= 1'b1;
        end
        if (core_reset_mod_exp) begin
            exp_cnt   <= lm + 1;
            exp_fin   <= 1'b0;
            model_out <= core_msg_in ^ {core_p, core_q} ^ {MW{core_encrypt_decrypt}};
        end else if (exp_cnt != 0) begin
            exp_cnt <= exp_cnt - 1;
            if (exp_cnt == 1) exp_fin <= 1'b1;
        end
    end

    assign core_inverter_finish = inv_fin | stale_inv;
    assign core_mod_exp_finish  = exp_fin;
    assign core_msg_out         = model_out;

    int   checks = 0;
    int   errors = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    int   order[$];

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] pp, input logic [W-1:0] qq,
                                input logic [MW-1:0] m, input logic e,
                                input int inv, input int lat);
        exp_t x;
        x.res = m ^ {pp, qq} ^ {MW{e}};
        x.err = 1'b0;
        x.inv = inv;
        x.mod = 1;
        x.lat = lat;
        return x;
    endfunction

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: pops the per-requester scoreboard on every done pulse.
    logic g, g_prev = 1'b0, who;
    logic zchk = 1'b0, btb = 1'b0, btb_on = 1'b0;
    int   lat = 0, n_inv = 0, n_mod = 0, gap_run = 0, gap_max = 0, sz;
    exp_t xm;

    always @(negedge clk) begin
        if (reset) begin
            g_prev = 1'b0;
            if (zchk) begin
                chk("rst_ctrl", MW'({grant0, grant1, done0, done1, err, busy,
                                     core_reset_inverter, core_reset_mod_exp}), '0);
                chk("rst_result", result, '0);
                chk("rst_core_pq", {core_p, core_q}, '0);
                chk("rst_core_msg", core_msg_in, '0);
                chk("rst_core_enc", MW'(core_encrypt_decrypt), '0);
            end
        end else begin
            g = grant0 | grant1;
            if (g && !g_prev) begin
                lat   = 0;
                n_inv = 0;
                n_mod = 0;
                order.push_back(grant1 ? 1 : 0);
            end else if (g) begin
                lat++;
            end
            if (core_reset_inverter) n_inv++;
            if (core_reset_mod_exp) n_mod++;
            if (core_reset_inverter && core_reset_mod_exp)
                chk("pulse_overlap", MW'(core_reset_mod_exp), '0);
            if (done0 || done1) begin
                who = done1;
                chk("done_onehot", MW'({done1, done0}), who ? MW'(2) : MW'(1));
                chk("grant_incl", MW'(who ? grant1 : grant0), MW'(1));
                sz = who ? sb1.size() : sb0.size();
                chk("sb_pending", MW'(sz != 0), MW'(1));
                if (sz != 0) begin
                    xm = who ? sb1.pop_front() : sb0.pop_front();
                    chk("result", result, xm.res);
                    chk("err", MW'(err), MW'(xm.err));
                    chk("inv_pulses", MW'(n_inv), MW'(xm.inv));
                    chk("exp_pulses", MW'(n_mod), MW'(xm.mod));
                    chk("latency", MW'(lat), MW'(xm.lat));
                end
            end
            if (btb && g) btb_on = 1'b1;
            if (btb && btb_on) begin
                if (!busy) begin
                    gap_run++;
                    if (gap_run > gap_max) gap_max = gap_run;
                end else begin
                    gap_run = 0;
                end
            end
            g_prev = g;
        end
    end

    task automatic job(input int r, input logic [W-1:0] pp, input logic [W-1:0] qq,
                       input logic [MW-1:0] m, input logic e, input exp_t x,
                       input int l_i, input int l_m);
        int n;
        if (r == 0) sb0.push_back(x);
        else sb1.push_back(x);
        n = 0;
        while ((r == 0 ? grant0 : grant1) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        li = l_i;
        lm = l_m;
        if (r == 0) begin
            p0 = pp; q0 = qq; msg0 = m; enc_dec0 = e; req0 = 1'b1;
        end else begin
            p1 = pp; q1 = qq; msg1 = m; enc_dec1 = e; req1 = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(r == 0 ? grant0 : grant1) && n < BUDGET);
        chk("grant_wait", MW'(r == 0 ? grant0 : grant1), MW'(1));
        if (r == 0) begin
            p0 = rnd128(); q0 = rnd128(); msg0 = {rnd128(), rnd128()}; enc_dec0 = ~e;
        end else begin
            p1 = rnd128(); q1 = rnd128(); msg1 = {rnd128(), rnd128()}; enc_dec1 = ~e;
        end
        n = 0;
        while (!(r == 0 ? done0 : done1) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", MW'(r == 0 ? done0 : done1), MW'(1));
        if (r == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    logic [W-1:0]  P1, Q1, P2, Q2, P3, Q3;
    logic [MW-1:0] MA;
    exp_t          xw;

    initial begin
        P1 = 128'd113680897410347;
        Q1 = 128'd7999808077935876437321;
        P2 = 128'h0123_4567_89ab_cdef_0fed_cba9_8765_4321;
        Q2 = 128'h8000_0000_0000_0000_0000_0000_0000_00c5;
        P3 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        Q3 = 128'h0000_0000_0000_0001_ffff_ffff_ffff_fff1;
        MA = 256'h3e18;
        MA = MA << 88;

        zchk = 1'b1;
        repeat (2) @(negedge clk);
        #1 zchk = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Cold key: 6 + 20 + 40.
        job(0, P1, Q1, MA, 1'b0, mk(P1, Q1, MA, 1'b0, 1, 66), 20, 40);
        // Same key from the other requester: cached, 3 + 40.
        job(1, P1, Q1, 256'h55aa_0f0f, 1'b1, mk(P1, Q1, 256'h55aa_0f0f, 1'b1, 0, 43), 20, 40);

        // Stale inverter finish held through INV_RST and INV_GUARD.
        stale_inv = 1'b1;
        fork
            job(0, P3, Q3, 256'h77, 1'b0, mk(P3, Q3, 256'h77, 1'b0, 1, 16), 5, 5);
            begin
                int n = 0;
                while (!core_reset_inverter && n < BUDGET) begin
                    @(negedge clk);
                    n++;
                end
                chk("stale_pulse_seen", MW'(core_reset_inverter), MW'(1));
                @(posedge clk);
                @(posedge clk);
                #1 stale_inv = 1'b0;
            end
        join

        // Cached job aborted by reset in EXP_WAIT.
        begin
            int n = 0;
            li = 30; lm = 30;
            p1 = P3; q1 = Q3; msg1 = 256'h99; enc_dec1 = 1'b0; req1 = 1'b1;
            do begin
                @(negedge clk);
                n++;
            end while (!grant1 && n < BUDGET);
            chk("abort_grant", MW'(grant1), MW'(1));
            repeat (4) @(negedge clk);
            chk("abort_busy", MW'(busy), MW'(1));
            @(posedge clk);
            #1 reset = 1'b1;
            zchk = 1'b1;
            @(negedge clk);
            #1 zchk = 1'b0;
            req1 = 1'b0;
            @(negedge clk);
            reset = 1'b0;
        end

        // Key cache was cleared by the reset.
        job(0, P3, Q3, 256'h1234, 1'b1, mk(P3, Q3, 256'h1234, 1'b1, 1, 11), 2, 3);

        // Both requesters high at reset release: grants alternate 0,1,0,1.
        @(negedge clk);
        reset = 1'b1;
        order.delete();
        btb = 1'b1;
        fork
            begin
                job(0, P1, Q1, 256'ha1, 1'b0, mk(P1, Q1, 256'ha1, 1'b0, 1, 13), 3, 4);
                job(0, P2, Q2, 256'ha2, 1'b1, mk(P2, Q2, 256'ha2, 1'b1, 1, 13), 3, 4);
            end
            begin
                job(1, P1, Q1, 256'hb1, 1'b1, mk(P1, Q1, 256'hb1, 1'b1, 0, 7), 3, 4);
                job(1, P2, Q2, 256'hb2, 1'b0, mk(P2, Q2, 256'hb2, 1'b0, 0, 7), 3, 4);
            end
            begin
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
        join
        btb = 1'b0;
        chk("idle_gap_max", MW'(gap_max), MW'(1));
        chk("order_len", MW'(order.size()), MW'(4));
        for (int i = 0; i < order.size() && i < 4; i++)
            chk("grant_order", MW'(order[i]), MW'(i % 2));

`ifdef RSA_WATCHDOG_EN
        // Inverter never finishes: timeout 100 cycles after entering INV_WAIT.
        xw = mk(P2, Q1, 256'hc3, 1'b0, 1, 102);
        xw.res = '0;
        xw.err = 1'b1;
        xw.mod = 0;
        job(0, P2, Q1, 256'hc3, 1'b0, xw, 100000, 100000);
        job(0, P2, Q1, 256'hc4, 1'b0, mk(P2, Q1, 256'hc4, 1'b0, 1, 8), 1, 1);
`else
        xw = mk(P2, Q1, 256'hc3, 1'b0, 1, 0);
`endif

        repeat (5) @(negedge clk);
        chk("sb_drained", MW'(sb0.size() + sb1.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
